// File: rtl/arbitro_enrutamiento_param_pkg.sv
// Shared constants for the PCIe transmit VC arbiter / destination router:
// arbitration mode encodings and default geometry.
package arbitro_enrutamiento_param_pkg;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_NUM_VC   = 4;
    localparam int DEF_NUM_DEST = 4;
    localparam int DEF_DATA_W   = 6;

endpackage

// File: rtl/arbitro_enrutamiento_param_rr_arbiter.sv
// Rotating priority arbiter: the request vector is rotated so that the current
// highest-priority index sits at bit 0, then the lowest set bit is picked.
module arbitro_enrutamiento_param_rr_arbiter
    import arbitro_enrutamiento_param_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    input  logic                  mode,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  gnt_valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] base_s;
    logic [N-1:0]  rot_s;
    logic [IW-1:0] off_s;
    logic          found_s;
    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Rotate requests by the priority base and priority-encode the lowest set bit
    always_comb begin
        base_s  = '0;
        found_s = 1'b0;
        off_s   = '0;
        if (mode == MODE_RR) begin
            base_s = ptr;
        end else begin
            base_s = '0;
        end
        // Doubling the vector makes the shift behave as a rotate in the low N bits
        rot_s = N'({req, req} >> base_s);
        for (int i = 0; i < N; i++) begin
            if (rot_s[i] && !found_s) begin
                found_s = 1'b1;
                off_s   = IW'(i);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = {1'b0, base_s} + {1'b0, off_s};
        if (sum_s >= (IW+1)'(N)) begin
            idx_s = IW'(sum_s - (IW+1)'(N));
        end else begin
            idx_s = sum_s[IW-1:0];
        end
    end

    // Gate the index by the valid flag so an idle cycle never leaks a stale grant
    always_comb begin
        gnt_valid = found_s;
        if (found_s) begin
            gnt_idx = idx_s;
            gnt     = N'(1'b1) << idx_s;
        end else begin
            gnt_idx = '0;
            gnt     = '0;
        end
    end

endmodule

// File: rtl/arbitro_enrutamiento_param.sv
// N-VC arbiter and M-destination router: pops one eligible FWFT head word per
// cycle and pushes it, one cycle later, to the FIFO named by its destination field.
module arbitro_enrutamiento_param
    import arbitro_enrutamiento_param_pkg::*;
#(
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int NUM_DEST = DEF_NUM_DEST,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arb_mode,
    input  logic [NUM_VC*DATA_W-1:0]     vc_data,
    input  logic [NUM_VC-1:0]            vc_empty,
    output logic [NUM_VC-1:0]            vc_pop,
    input  logic [NUM_DEST-1:0]          d_almost_full,
    output logic [NUM_DEST-1:0]          d_push,
    output logic [NUM_DEST*DATA_W-1:0]   d_data,
    output logic                         busy
);

    localparam int DEST_W = $clog2(NUM_DEST);
    localparam int VW     = $clog2(NUM_VC);

    logic [NUM_VC-1:0]          elig_s;
    logic [NUM_VC-1:0]          gnt_s;
    logic [VW-1:0]              gnt_idx_s;
    logic                       gnt_valid_s;
    logic [VW-1:0]              rr_ptr_r;
    logic [DATA_W-1:0]          word_s;
    logic [DEST_W-1:0]          dest_s;
    logic [NUM_DEST-1:0]        d_push_r;
    logic [NUM_DEST*DATA_W-1:0] d_data_r;
    logic                       busy_r;

    // A VC blocked on a full destination drops out of the request mask, so it never holds up others
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!vc_empty[i] && !d_almost_full[vc_data[i*DATA_W + DATA_W - 1 -: DEST_W]]) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
    end

    arbitro_enrutamiento_param_rr_arbiter #(
        .N (NUM_VC)
    ) u_rr_arbiter (
        .req       (elig_s),
        .ptr       (rr_ptr_r),
        .mode      (arb_mode),
        .gnt       (gnt_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // Select the granted head word and drive the FWFT pop strobe, suppressed while in reset
    always_comb begin
        word_s = vc_data[gnt_idx_s*DATA_W +: DATA_W];
        dest_s = word_s[DATA_W-1 -: DEST_W];
        if (reset) begin
            vc_pop = '0;
        end else begin
            vc_pop = gnt_s;
        end
    end

    // Round-robin pointer advances past the winner only in RR mode and survives mode switches
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if ((arb_mode == MODE_RR) && gnt_valid_s) begin
            if (gnt_idx_s == VW'(NUM_VC - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + VW'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Output bank: one-hot push plus the word in its destination slice; other slices hold
    always_ff @(posedge clk) begin
        if (reset) begin
            d_push_r <= '0;
            d_data_r <= '0;
            busy_r   <= 1'b0;
        end else if (gnt_valid_s) begin
            d_push_r <= NUM_DEST'(1'b1) << dest_s;
            d_data_r[dest_s*DATA_W +: DATA_W] <= word_s;
            busy_r   <= 1'b1;
        end else begin
            d_push_r <= '0;
            busy_r   <= 1'b0;
        end
    end

    assign d_push = d_push_r;
    assign d_data = d_data_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// Directed plus random bench for the VC arbiter/router, checked against a
// queue-free behavioural model of the grant/push rules.
module tb_arbitro_enrutamiento_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arb_mode = 1'b0;
    logic [23:0] vc_data = 24'd0;
    logic [3:0]  vc_empty = 4'hF;
    logic [3:0]  vc_pop;
    logic [3:0]  d_almost_full = 4'h0;
    logic [3:0]  d_push;
    logic [23:0] d_data;
    logic        busy;

    int total = 0;
    int bad = 0;

    // reference model state
    int         m_ptr = 0;
    logic [3:0] m_push = 4'h0;
    logic [5:0] m_data [4] = '{6'h0, 6'h0, 6'h0, 6'h0};
    logic       m_busy = 1'b0;

    arbitro_enrutamiento_param dut (
        .clk           (clk),
        .reset         (reset),
        .arb_mode      (arb_mode),
        .vc_data       (vc_data),
        .vc_empty      (vc_empty),
        .vc_pop        (vc_pop),
        .d_almost_full (d_almost_full),
        .d_push        (d_push),
        .d_data        (d_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // First eligible VC when scanning from the priority base, -1 if none
    function automatic int ref_grant(input logic mode, input logic [23:0] data,
                                     input logic [3:0] empty, input logic [3:0] af);
        int base;
        logic [5:0] w;
        base = mode ? m_ptr : 0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (base + k) % 4;
            w = data[c*6 +: 6];
            if (!empty[c] && !af[w[5:4]]) return c;
        end
        return -1;
    endfunction

    task automatic step(input logic rst, input logic mode, input logic [23:0] data,
                        input logic [3:0] empty, input logic [3:0] af, input string tag);
        int g;
        logic [5:0] w;
        @(negedge clk);
        reset = rst;
        arb_mode = mode;
        vc_data = data;
        vc_empty = empty;
        d_almost_full = af;
        #1;
        g = rst ? -1 : ref_grant(mode, data, empty, af);
        chk({tag, ".pop"}, {28'd0, vc_pop}, (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk);
        #1;
        if (rst) begin
            m_push = 4'h0;
            for (int j = 0; j < 4; j++) m_data[j] = 6'h0;
            m_busy = 1'b0;
            m_ptr = 0;
        end else if (g >= 0) begin
            w = data[g*6 +: 6];
            m_push = 4'b0001 << w[5:4];
            m_data[w[5:4]] = w;
            m_busy = 1'b1;
            if (mode) m_ptr = (g + 1) % 4;
        end else begin
            m_push = 4'h0;
            m_busy = 1'b0;
        end
        chk({tag, ".push"}, {28'd0, d_push}, {28'd0, m_push});
        chk({tag, ".data"}, {8'd0, d_data}, {8'd0, m_data[3], m_data[2], m_data[1], m_data[0]});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    endtask

    initial begin
        // 1) reset hold with every VC holding a word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'hFEDCBA, 4'b0000, 4'h0, "rst_hold");

        // 2) strict priority: VC0 (6'h31 -> dest 3) beats VC2 (6'h05 -> dest 0)
        step(1'b0, 1'b0, {6'h00, 6'h05, 6'h00, 6'h31}, 4'b1010, 4'h0, "strict_a");
        chk("strict_a.slice3", {26'd0, d_data[23:18]}, 32'h31);
        step(1'b0, 1'b0, {6'h00, 6'h05, 6'h00, 6'h31}, 4'b1110, 4'h0, "strict_b");

        // 3) round-robin across all four VCs for six cycles
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, {6'h33, 6'h22, 6'h11, 6'h00}, 4'b0000, 4'h0, "rr_wrap");

        // 4) HOL bypass: VC0 blocked on dest 2, VC1 to dest 1 goes through
        step(1'b0, 1'b0, {6'h00, 6'h00, 6'h11, 6'h2A}, 4'b1100, 4'b0100, "hol_a");
        chk("hol_a.slice1", {26'd0, d_data[11:6]}, 32'h11);
        step(1'b0, 1'b0, {6'h00, 6'h00, 6'h11, 6'h2A}, 4'b1110, 4'b0100, "hol_b");
        step(1'b0, 1'b0, {6'h00, 6'h00, 6'h11, 6'h2A}, 4'b1110, 4'b0000, "hol_c");

        // 5) backpressure race on dest 3
        step(1'b0, 1'b0, {6'h3F, 6'h00, 6'h00, 6'h00}, 4'b0111, 4'h0, "race_t");
        step(1'b0, 1'b0, {6'h3F, 6'h00, 6'h00, 6'h00}, 4'b0111, 4'b1000, "race_t1");

        // 6) mid-operation reset in RR mode, then first grant must return to VC0
        step(1'b0, 1'b1, {6'h33, 6'h22, 6'h11, 6'h00}, 4'b1011, 4'h0, "mid_pre");
        step(1'b1, 1'b1, {6'h33, 6'h22, 6'h11, 6'h00}, 4'b0000, 4'h0, "mid_rst");
        step(1'b0, 1'b1, {6'h33, 6'h22, 6'h11, 6'h00}, 4'b0000, 4'h0, "mid_post");

        // random traffic with mode flips, backpressure and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic rr, mm;
            logic [3:0] af;
            rr = ($urandom_range(0, 39) == 0);
            mm = 1'(($urandom_range(0, 9) < 7) ? 1 : 0);
            af = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            step(rr, mm, 24'($urandom), 4'($urandom), af, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
